// File: rtl/canny_pkg.sv
// Shared state encoding and default thresholds for the Canny frame controller.
package canny_pkg;

   localparam int TH_W = 11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_VBLANK = 2'd1,
      ST_LINE   = 2'd2,
      ST_HBLANK = 2'd3
   } state_t;

   localparam logic [TH_W-1:0] DEF_HIGH_TH = TH_W'(100);
   localparam logic [TH_W-1:0] DEF_LOW_TH  = TH_W'(40);

endpackage

// File: rtl/canny_sync_edge.sv
// Registers HSYNC/VSYNC/BLANK once and derives rise/fall pulses from the registered copies.
module canny_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_hsync,
   input  logic i_vsync,
   input  logic i_blank,
   output logic blank_lvl,
   output logic hs_rise,
   output logic hs_fall,
   output logic vs_rise,
   output logic vs_fall,
   output logic bl_rise,
   output logic bl_fall
);

   // Bit order {hsync, vsync, blank}; reset to the inactive levels so no edge fires out of reset.
   logic [2:0] sync_q, sync_d;
   logic [2:0] prev_q, prev_d;

   always_comb begin
      sync_d = {i_hsync, i_vsync, i_blank};
      prev_d = sync_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 3'b111;
         prev_q <= 3'b111;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign blank_lvl = sync_q[0];
   assign hs_rise   =  sync_q[2] & ~prev_q[2];
   assign hs_fall   = ~sync_q[2] &  prev_q[2];
   assign vs_rise   =  sync_q[1] & ~prev_q[1];
   assign vs_fall   = ~sync_q[1] &  prev_q[1];
   assign bl_rise   =  sync_q[0] & ~prev_q[0];
   assign bl_fall   = ~sync_q[0] &  prev_q[0];

endmodule

// File: rtl/canny_frame_ctrl.sv
// Frame/line sequencer with frame-boundary threshold shadowing for the Canny pipeline.
// Optional per-frame edge statistics are built when CANNY_CTRL_STATS_EN is defined.
module canny_frame_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int CNT_W    = 11,
   parameter int TH_W     = canny_pkg::TH_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_HSYNC,
   input  logic             i_VSYNC,
   input  logic             i_BLANK,
   input  logic [TH_W-1:0]  cfg_high_th,
   input  logic [TH_W-1:0]  cfg_low_th,
   input  logic             cfg_wr,
`ifdef CANNY_CTRL_STATS_EN
   input  logic             i_is_edge,
   output logic [2*CNT_W-1:0] o_edge_count,
`endif
   output logic             cfg_ack,
   output logic [TH_W-1:0]  o_high_th,
   output logic [TH_W-1:0]  o_low_th,
   output logic [CNT_W-1:0] o_x,
   output logic [CNT_W-1:0] o_y,
   output logic             o_pix_valid,
   output logic             o_border,
   output logic             o_frame_start,
   output logic             o_line_start,
   output logic             o_fmt_err,
   output logic [1:0]       o_state
);
   import canny_pkg::*;

   localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] Y_END  = CNT_W'(V_ACTIVE);

   logic blank_lvl, hs_rise, hs_fall, vs_rise, vs_fall, bl_rise, bl_fall;
   logic unused_edges;

   canny_sync_edge u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_hsync   (i_HSYNC),
      .i_vsync   (i_VSYNC),
      .i_blank   (i_BLANK),
      .blank_lvl (blank_lvl),
      .hs_rise   (hs_rise),
      .hs_fall   (hs_fall),
      .vs_rise   (vs_rise),
      .vs_fall   (vs_fall),
      .bl_rise   (bl_rise),
      .bl_fall   (bl_fall)
   );

   // Line sequencing runs off BLANK levels; the remaining edge pulses are spare.
   assign unused_edges = ^{hs_rise, hs_fall, vs_rise, bl_rise, bl_fall};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
   logic             pix_valid_q, pix_valid_d, border_q, border_d;
   logic             fs_q, fs_d, ls_q, ls_d, fmt_err_q, fmt_err_d;
   logic [TH_W-1:0]  high_q, high_d, low_q, low_d, pend_high_q, pend_high_d, pend_low_q, pend_low_d;
   logic             pend_q, pend_d, ack_q, ack_d;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      pix_valid_d = 1'b0;
      fs_d        = 1'b0;
      ls_d        = 1'b0;
      fmt_err_d   = fmt_err_q;
      if (vs_fall) begin
         state_d = ST_VBLANK;
         x_d     = '0;
         y_d     = '0;
         fs_d    = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_VBLANK: begin
               if (!blank_lvl) begin
                  // Active video after the last line of a frame is a format error, not a pixel.
                  if (y_q == Y_END) begin
                     fmt_err_d = 1'b1;
                  end else begin
                     state_d     = ST_LINE;
                     x_d         = '0;
                     pix_valid_d = 1'b1;
                     ls_d        = 1'b1;
                  end
               end
            end
            ST_LINE: begin
               if (blank_lvl) begin
                  state_d = ST_HBLANK;
                  y_d     = y_q + CNT_W'(1);
               end else begin
                  pix_valid_d = 1'b1;
                  if (x_q == X_LAST) fmt_err_d = 1'b1;
                  else               x_d = x_q + CNT_W'(1);
               end
            end
            ST_HBLANK: begin
               if (y_q == Y_END) begin
                  state_d = ST_VBLANK;
               end else if (!blank_lvl) begin
                  state_d     = ST_LINE;
                  x_d         = '0;
                  pix_valid_d = 1'b1;
                  ls_d        = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      border_d = pix_valid_d &&
                 ((x_d == '0) || (x_d == X_LAST) || (y_d == '0) || (y_d == Y_LAST));
   end

   // A write landing on the apply cycle stays pending; the older values go out now.
   always_comb begin
      high_d      = high_q;
      low_d       = low_q;
      ack_d       = 1'b0;
      pend_d      = pend_q;
      pend_high_d = pend_high_q;
      pend_low_d  = pend_low_q;
      if (fs_d && pend_q) begin
         high_d = pend_high_q;
         low_d  = (pend_low_q > pend_high_q) ? pend_high_q : pend_low_q;
         ack_d  = 1'b1;
         pend_d = 1'b0;
      end
      if (cfg_wr) begin
         pend_high_d = cfg_high_th;
         pend_low_d  = cfg_low_th;
         pend_d      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         pix_valid_q <= 1'b0;
         border_q    <= 1'b0;
         fs_q        <= 1'b0;
         ls_q        <= 1'b0;
         fmt_err_q   <= 1'b0;
         high_q      <= TH_W'(DEF_HIGH_TH);
         low_q       <= TH_W'(DEF_LOW_TH);
         ack_q       <= 1'b0;
         pend_q      <= 1'b0;
         pend_high_q <= '0;
         pend_low_q  <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         pix_valid_q <= pix_valid_d;
         border_q    <= border_d;
         fs_q        <= fs_d;
         ls_q        <= ls_d;
         fmt_err_q   <= fmt_err_d;
         high_q      <= high_d;
         low_q       <= low_d;
         ack_q       <= ack_d;
         pend_q      <= pend_d;
         pend_high_q <= pend_high_d;
         pend_low_q  <= pend_low_d;
      end
   end

`ifdef CANNY_CTRL_STATS_EN
   logic [2*CNT_W-1:0] ecnt_q, ecnt_d, ecount_q, ecount_d;

   always_comb begin
      ecnt_d   = ecnt_q;
      ecount_d = ecount_q;
      if (fs_q) begin
         ecount_d = ecnt_q;
         ecnt_d   = '0;
      end else if (pix_valid_q && i_is_edge && (ecnt_q != '1)) begin
         ecnt_d = ecnt_q + (2*CNT_W)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ecnt_q   <= '0;
         ecount_q <= '0;
      end else begin
         ecnt_q   <= ecnt_d;
         ecount_q <= ecount_d;
      end
   end

   assign o_edge_count = ecount_q;
`endif

   assign cfg_ack       = ack_q;
   assign o_high_th     = high_q;
   assign o_low_th      = low_q;
   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_pix_valid   = pix_valid_q;
   assign o_border      = border_q;
   assign o_frame_start = fs_q;
   assign o_line_start  = ls_q;
   assign o_fmt_err     = fmt_err_q;
   assign o_state       = state_q;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Directed bench for canny_frame_ctrl on an 8x4 frame geometry.
module tb_canny_frame_ctrl;

   localparam int H = 8;
   localparam int V = 4;
   localparam int CW = 11;
   localparam int TW = 11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_HSYNC = 1'b1, i_VSYNC = 1'b1, i_BLANK = 1'b1;
   logic [TW-1:0] cfg_high_th = '0, cfg_low_th = '0;
   logic          cfg_wr = 1'b0;
   logic          cfg_ack;
   logic [TW-1:0] o_high_th, o_low_th;
   logic [CW-1:0] o_x, o_y;
   logic          o_pix_valid, o_border, o_frame_start, o_line_start, o_fmt_err;
   logic [1:0]    o_state;
`ifdef CANNY_CTRL_STATS_EN
   logic            i_is_edge = 1'b0;
   logic [2*CW-1:0] o_edge_count;
   int              edge_budget = 0;
   int              edges_sent = 0;
`endif

   canny_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW), .TH_W(TW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_HSYNC       (i_HSYNC),
      .i_VSYNC       (i_VSYNC),
      .i_BLANK       (i_BLANK),
      .cfg_high_th   (cfg_high_th),
      .cfg_low_th    (cfg_low_th),
      .cfg_wr        (cfg_wr),
`ifdef CANNY_CTRL_STATS_EN
      .i_is_edge     (i_is_edge),
      .o_edge_count  (o_edge_count),
`endif
      .cfg_ack       (cfg_ack),
      .o_high_th     (o_high_th),
      .o_low_th      (o_low_th),
      .o_x           (o_x),
      .o_y           (o_y),
      .o_pix_valid   (o_pix_valid),
      .o_border      (o_border),
      .o_frame_start (o_frame_start),
      .o_line_start  (o_line_start),
      .o_fmt_err     (o_fmt_err),
      .o_state       (o_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   // monitor: accumulates observations on the falling edge
   int         n_valid = 0, n_border = 0, n_ls = 0, n_fs = 0, n_ack = 0;
   logic       fs_ack = 1'b0;
   logic [TW-1:0] fs_high = '0, fs_low = '0;
   logic [7:0] pix_q[$];
   logic [7:0] exp_q[$];

   always @(negedge clk) begin
      if (o_pix_valid) begin
         n_valid++;
         pix_q.push_back({o_y[3:0], o_x[3:0]});
         if (o_border) n_border++;
      end
      if (o_line_start) n_ls++;
      if (o_frame_start) begin
         n_fs++;
         fs_ack  = cfg_ack;
         fs_high = o_high_th;
         fs_low  = o_low_th;
      end
      if (cfg_ack) n_ack++;
`ifdef CANNY_CTRL_STATS_EN
      i_is_edge = o_pix_valid && (edges_sent < edge_budget);
      if (i_is_edge) edges_sent++;
`endif
   end

   int b_valid, b_border, b_ls, b_fs, b_ack, b_pix;

   task automatic mark();
      b_valid = n_valid; b_border = n_border; b_ls = n_ls;
      b_fs = n_fs; b_ack = n_ack; b_pix = pix_q.size();
   endtask

   // scoreboard counters
   int n_checks = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // drivers
   task automatic drive(input logic hs, input logic vs, input logic bl);
      @(negedge clk);
      i_HSYNC = hs; i_VSYNC = vs; i_BLANK = bl;
   endtask

   task automatic vsync_pulse();
      drive(1, 0, 1); drive(1, 0, 1);
      repeat (3) drive(1, 1, 1);
   endtask

   task automatic send_line(input int n);
      repeat (n) drive(1, 1, 0);
      repeat (2) drive(1, 1, 1);
      drive(0, 1, 1);
      repeat (2) drive(1, 1, 1);
   endtask

   task automatic send_frame(input int lines, input int pix);
      vsync_pulse();
      for (int l = 0; l < lines; l++) send_line(pix);
      repeat (3) drive(1, 1, 1);
   endtask

   task automatic cfg_write(input logic [TW-1:0] hi, input logic [TW-1:0] lo);
      @(negedge clk);
      cfg_wr = 1'b1; cfg_high_th = hi; cfg_low_th = lo;
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   typedef struct {
      logic [TW-1:0] hi;
      logic [TW-1:0] lo;
      logic [TW-1:0] exp_hi;
      logic [TW-1:0] exp_lo;
   } th_vec_t;

   th_vec_t       tv[4];
   logic [TW-1:0] prev_h, prev_l;
   logic [7:0]    pe;

   initial begin
      tv[0] = '{hi: 11'd200,  lo: 11'd50, exp_hi: 11'd200,  exp_lo: 11'd50};
      tv[1] = '{hi: 11'd30,   lo: 11'd60, exp_hi: 11'd30,   exp_lo: 11'd30};
      tv[2] = '{hi: 11'd2047, lo: 11'd0,  exp_hi: 11'd2047, exp_lo: 11'd0};
      tv[3] = '{hi: 11'd0,    lo: 11'd5,  exp_hi: 11'd0,    exp_lo: 11'd0};

      // reset
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) drive(1, 1, 1);
      check("reset_high_th", o_high_th, 100);
      check("reset_low_th", o_low_th, 40);
      check("reset_state", o_state, 0);
      check("reset_pix_valid", o_pix_valid, 0);
      check("reset_fmt_err", o_fmt_err, 0);
      check("reset_cfg_ack", cfg_ack, 0);

      // pixels before any VSYNC are ignored
      mark();
      send_line(8);
      check("pre_vsync_valid", n_valid - b_valid, 0);
      check("pre_vsync_state", o_state, 0);

      // one clean frame
      mark();
      send_frame(V, H);
      check("clean_valid", n_valid - b_valid, 32);
      check("clean_border", n_border - b_border, 20);
      check("clean_line_start", n_ls - b_ls, 4);
      check("clean_frame_start", n_fs - b_fs, 1);
      check("clean_fmt_err", o_fmt_err, 0);
      check("clean_state", o_state, 1);
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) exp_q.push_back({4'(y), 4'(x)});
      for (int i = 0; i < 32; i++) begin
         pe = exp_q.pop_front();
         check($sformatf("clean_xy[%0d]", i), pix_q[b_pix + i], pe);
      end

      // threshold vectors: write mid-frame, hold until boundary, apply with ack
      prev_h = 11'd100; prev_l = 11'd40;
      for (int i = 0; i < 4; i++) begin
         vsync_pulse();
         send_line(H);
         cfg_write(tv[i].hi, tv[i].lo);
         repeat (V - 1) send_line(H);
         repeat (3) drive(1, 1, 1);
         check($sformatf("tv%0d_hold_high", i), o_high_th, prev_h);
         check($sformatf("tv%0d_hold_low", i), o_low_th, prev_l);
         mark();
         vsync_pulse();
         check($sformatf("tv%0d_ack_count", i), n_ack - b_ack, 1);
         check($sformatf("tv%0d_ack_on_fs", i), fs_ack, 1);
         check($sformatf("tv%0d_high_on_fs", i), fs_high, tv[i].exp_hi);
         check($sformatf("tv%0d_low_on_fs", i), fs_low, tv[i].exp_lo);
         prev_h = tv[i].exp_hi; prev_l = tv[i].exp_lo;
      end

      // write landing on the apply cycle
      cfg_write(11'd200, 11'd50);
      mark();
      @(negedge clk); i_VSYNC = 1'b0;
      @(negedge clk); cfg_wr = 1'b1; cfg_high_th = 11'd90; cfg_low_th = 11'd10;
      @(negedge clk); cfg_wr = 1'b0; i_VSYNC = 1'b1;
      repeat (3) drive(1, 1, 1);
      check("same_cycle_ack1", n_ack - b_ack, 1);
      check("same_cycle_high1", fs_high, 200);
      check("same_cycle_low1", fs_low, 50);
      mark();
      send_frame(V, H);
      check("same_cycle_ack2", n_ack - b_ack, 1);
      check("same_cycle_high2", o_high_th, 90);
      check("same_cycle_low2", o_low_th, 10);
      mark();
      send_frame(V, H);
      check("no_pending_no_ack", n_ack - b_ack, 0);
      check("no_pending_high", o_high_th, 90);

      // overlong line saturates x and sets the sticky error
      mark();
      vsync_pulse();
      send_line(10);
      repeat (V - 1) send_line(H);
      repeat (3) drive(1, 1, 1);
      check("long_valid", n_valid - b_valid, 34);
      check("long_x_sat", pix_q[b_pix + 9][3:0], 7);
      check("long_fmt_err", o_fmt_err, 1);
      mark();
      send_frame(V, H);
      check("long_next_fs", n_fs - b_fs, 1);
      check("long_fmt_sticky", o_fmt_err, 1);

      // reset mid-line returns to IDLE and stays quiet without VSYNC
      vsync_pulse();
      send_line(H);
      repeat (3) drive(1, 1, 0);
      @(negedge clk); rst_n = 1'b0;
      #1;
      check("midreset_state", o_state, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mark();
      repeat (5) drive(1, 1, 0);
      send_line(H);
      check("midreset_quiet", n_valid - b_valid, 0);
      check("midreset_fmt_err", o_fmt_err, 0);
      check("midreset_high", o_high_th, 100);
      check("midreset_low", o_low_th, 40);

      // active video after the last line of a frame
      mark();
      send_frame(V, H);
      check("post_frame_fmt0", o_fmt_err, 0);
      send_line(3);
      check("post_frame_fmt1", o_fmt_err, 1);
      check("post_frame_valid", n_valid - b_valid, 32);

      // VSYNC resync mid-frame at y=2
      vsync_pulse();
      send_line(H); send_line(H);
      repeat (3) drive(1, 1, 0);
      drive(1, 0, 1); drive(1, 0, 1); drive(1, 1, 1);
      check("resync_state", o_state, 1);
      check("resync_x", o_x, 0);
      check("resync_y", o_y, 0);
      mark();
      repeat (V) send_line(H);
      repeat (3) drive(1, 1, 1);
      check("resync_valid", n_valid - b_valid, 32);
      check("resync_first", pix_q[b_pix], 8'h00);
      check("resync_last", pix_q[b_pix + 31], 8'h37);
      check("resync_ls", n_ls - b_ls, 4);

`ifdef CANNY_CTRL_STATS_EN
      edge_budget = edges_sent + 5;
      send_frame(V, H);
      vsync_pulse();
      check("edge_count", o_edge_count, 5);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
